chunked_serial_adder: RTL and testbench
=======================================

// Module: chunked_serial_adder
// PURPOSE
//   Multi-cycle WIDTH-bit adder. Adds CHUNK bits per clock using a registered carry
//   between chunks, so one small adder slice is reused WIDTH/CHUNK times.
//   Parametrised, clocked successor of the team's combinational half-adder.
//   Used where area matters more than latency; start/busy/done handshake to the controller.
// PARAMETERS
//   WIDTH  8  operand and sum width in bits; must be >= 1
//   CHUNK  2  bits added per cycle; 1 <= CHUNK <= WIDTH; WIDTH % CHUNK == 0
//   NCHK   (localparam) WIDTH/CHUNK, number of RUN cycles; counter is $clog2(NCHK+1) bits
// PORTS
//   clk    in   1      clock, rising edge
//   rst    in   1      reset, asynchronous, active-high
//   start  in   1      request: capture a, b, cin and begin an add
//   a      in   WIDTH  operand A, sampled only on an accepted start
//   b      in   WIDTH  operand B, sampled only on an accepted start
//   cin    in   1      carry-in, sampled only on an accepted start
//   busy   out  1      high while state == RUN
//   done   out  1      one-cycle pulse: sum, carry and ovf are valid
//   sum    out  WIDTH  result a+b+cin mod 2^WIDTH, registered
//   carry  out  1      carry-out of the MSB, registered
//   ovf    out  1      signed overflow flag; see CONFIGURATION
// BEHAVIOUR
//   Reset (async, any time): state=IDLE; busy=0, done=0, sum=0, carry=0, ovf=0;
//     operand shift regs, carry reg and chunk counter cleared.
//     An add in progress is abandoned and no done pulse follows.
//   FSM states: IDLE, RUN, DONE.
//   IDLE: start=1 at edge E0 -> load opA=a, opB=b, creg=cin, cnt=0; next state RUN.
//   RUN: each edge adds {opA[CHUNK-1:0]} + {opB[CHUNK-1:0]} + creg.
//     - Low CHUNK result bits shift into the top of the partial-sum reg.
//     - creg <= chunk carry; opA and opB shift right by CHUNK; cnt++.
//     - At the edge where cnt reaches NCHK (edge E_NCHK): sum <= partial, carry <= creg_next,
//       ovf updated; next state DONE.
//   DONE: done=1 for exactly one cycle.
//     - start=0 -> IDLE.
//     - start=1 -> accept new operands exactly as in IDLE, next state RUN (back-to-back).
//   Latency: start sampled at E0 -> done high in the cycle after edge E_NCHK.
//     Throughput: one add per NCHK+1 cycles.
//   start while RUN: ignored; operands not captured, no queueing.
//   sum/carry/ovf change only on the completing edge and hold until the next completion.
//     They never show partial results.
//   CHUNK == WIDTH: NCHK=1; a single RUN cycle, then DONE.
//   Arithmetic is unsigned modulo 2^WIDTH. carry equals bit WIDTH of a+b+cin.
// CONFIGURATION
//   ADDER_OVF_DETECT_EN defined:
//     - ovf <= (a[MSB]==b[MSB]) && (sum[MSB]!=a[MSB]) on the completing edge.
//     - The MSB of each operand is retained in a separate register from capture.
//   ADDER_OVF_DETECT_EN undefined:
//     - ovf port is present and tied to 0; no MSB-retain registers are built.
// TESTING
//   Default parameters: WIDTH=8, CHUNK=2.
//   T1 a=0x00,b=0x00,cin=0, start 1 cycle -> busy 4 cycles, done in 5th; sum=0x00, carry=0, ovf=0.
//   T2 a=0xFF,b=0x01,cin=0 -> sum=0x00, carry=1, ovf=0. a=0xFF,b=0xFF,cin=1 -> sum=0xFF, carry=1.
//   T3 a=0x7F,b=0x01,cin=0 -> sum=0x80, carry=0; ovf=1 with macro, ovf=0 without.
//   T4 start a=0x10,b=0x20; re-assert start with a=0xAA during RUN -> ignored; done with sum=0x30.
//   T5 rst pulse in 2nd RUN cycle -> all outputs 0 immediately; no done; next start a=3,b=4 -> sum=0x07.
//   T6 start held high through DONE -> second add accepted in DONE cycle; done again 5 cycles later.
//   T6 (cont.) Exhaustive WIDTH=4 with CHUNK=1,2,4: all a, b, cin vs reference a+b+cin.

Source files
------------

// File: rtl/chunked_serial_adder_if.sv
// Operand/handshake bundle between a controller and chunked_serial_adder.
// Latency: none, wires only. Backpressure: the controller watches busy/done before it re-asserts start.
interface chunked_serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             ovf;

  modport master (output start, a, b, cin, input busy, done, sum, carry, ovf);
  modport slave  (input start, a, b, cin, output busy, done, sum, carry, ovf);
endinterface

// File: rtl/chunked_serial_adder.sv
// Serial WIDTH-bit adder, CHUNK bits per clock; ADDER_OVF_DETECT_EN enables the signed-overflow flag.
// Latency: start accepted at edge E0, done pulses in the cycle after edge E0+WIDTH/CHUNK.
// Backpressure: start is ignored while busy; it is accepted in IDLE and in the DONE cycle.
module chunked_serial_adder #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  chunked_serial_adder_if.slave bus
);
  localparam int NCHK = WIDTH / CHUNK;
  localparam int CW   = $clog2(NCHK + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] opa, opb;
  logic [WIDTH-1:0] partial_nxt;
  logic [WIDTH-1:0] sum_q;
  logic             creg, carry_q;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [CHUNK:0]   chunk_res;
  logic             accept, last;

  assign chunk_res = {1'b0, opa[CHUNK-1:0]} + {1'b0, opb[CHUNK-1:0]} + {{CHUNK{1'b0}}, creg};
  assign cnt_nxt   = cnt + CW'(1);

  // Only the upper WIDTH-CHUNK bits need storage: the final chunk goes straight into sum.
  generate
    if (CHUNK == WIDTH) begin : g_single
      assign partial_nxt = chunk_res[CHUNK-1:0];
    end else begin : g_shift
      logic [WIDTH-CHUNK-1:0] hi;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)                hi <= '0;
        else if (state == RUN)  hi <= partial_nxt[WIDTH-1:CHUNK];
      end
      assign partial_nxt = {chunk_res[CHUNK-1:0], hi};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (cnt_nxt == CW'(NCHK)) begin
          last      = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opa     <= '0;
      opb     <= '0;
      creg    <= 1'b0;
      cnt     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else if (accept) begin
      opa  <= bus.a;
      opb  <= bus.b;
      creg <= bus.cin;
      cnt  <= '0;
    end else if (state == RUN) begin
      opa  <= opa >> CHUNK;
      opb  <= opb >> CHUNK;
      creg <= chunk_res[CHUNK];
      cnt  <= cnt_nxt;
      if (last) begin
        sum_q   <= partial_nxt;
        carry_q <= chunk_res[CHUNK];
      end
    end
  end

  assign bus.busy  = (state == RUN);
  assign bus.done  = (state == DONE);
  assign bus.sum   = sum_q;
  assign bus.carry = carry_q;

`ifdef ADDER_OVF_DETECT_EN
  logic a_msb, b_msb, ovf_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      if (accept) begin
        a_msb <= bus.a[WIDTH-1];
        b_msb <= bus.b[WIDTH-1];
      end
      if (last) ovf_q <= (a_msb == b_msb) && (partial_nxt[WIDTH-1] != a_msb);
    end
  end
  assign bus.ovf = ovf_q;
`else
  assign bus.ovf = 1'b0;
`endif
endmodule

// File: tb/tb_chunked_serial_adder.sv
// Self-checking bench for chunked_serial_adder: directed cases, random 8-bit adds and exhaustive 4-bit sweeps.
// Expected results come from a plain-arithmetic reference model.
module tb_chunked_serial_adder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  chunked_serial_adder_if #(.WIDTH(8)) bus8 ();
  chunked_serial_adder #(.WIDTH(8), .CHUNK(2)) dut (.clk(clk), .rst(rst), .bus(bus8));

  logic       s4_start;
  logic [3:0] s4_a, s4_b;
  logic       s4_cin;

  chunked_serial_adder_if #(.WIDTH(4)) if4_1 ();
  chunked_serial_adder_if #(.WIDTH(4)) if4_2 ();
  chunked_serial_adder_if #(.WIDTH(4)) if4_4 ();
  chunked_serial_adder #(.WIDTH(4), .CHUNK(1)) u4_1 (.clk(clk), .rst(rst), .bus(if4_1));
  chunked_serial_adder #(.WIDTH(4), .CHUNK(2)) u4_2 (.clk(clk), .rst(rst), .bus(if4_2));
  chunked_serial_adder #(.WIDTH(4), .CHUNK(4)) u4_4 (.clk(clk), .rst(rst), .bus(if4_4));

  assign if4_1.start = s4_start;
  assign if4_1.a     = s4_a;
  assign if4_1.b     = s4_b;
  assign if4_1.cin   = s4_cin;
  assign if4_2.start = s4_start;
  assign if4_2.a     = s4_a;
  assign if4_2.b     = s4_b;
  assign if4_2.cin   = s4_cin;
  assign if4_4.start = s4_start;
  assign if4_4.a     = s4_a;
  assign if4_4.b     = s4_b;
  assign if4_4.cin   = s4_cin;

  // Reference: unsigned sum/carry from integer addition, overflow as signed out-of-range.
  function automatic void ref_add(input int w, input longint a, input longint b, input longint cin,
                                  output longint s, output bit c, output bit v);
    longint m, full;
    m    = longint'(1) << w;
    full = a + b + cin;
    s    = full % m;
    c    = (full >= m);
`ifdef ADDER_OVF_DETECT_EN
    begin
      longint sa, sb, ss;
      sa = (a >= m / 2) ? a - m : a;
      sb = (b >= m / 2) ? b - m : b;
      ss = sa + sb + cin;
      v  = (ss >= m / 2) || (ss < -(m / 2));
    end
`else
    v = 1'b0;
`endif
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full add on the 8-bit instance; poke re-asserts start with new data mid-RUN.
  task automatic add8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                      input bit poke, input string tag);
    longint es;
    bit     ec, ev;
    int     lat, busy_cnt;
    ref_add(8, longint'(a), longint'(b), longint'(cin), es, ec, ev);
    bus8.start = 1'b1;
    bus8.a     = a;
    bus8.b     = b;
    bus8.cin   = cin;
    tick();
    bus8.start = 1'b0;
    lat        = 0;
    busy_cnt   = 0;
    while (bus8.done !== 1'b1 && lat < 20) begin
      if (bus8.busy === 1'b1) busy_cnt++;
      if (poke) begin
        bus8.start = (lat == 0);
        if (lat == 0) bus8.a = 8'hAA;
      end
      tick();
      lat++;
    end
    bus8.start = 1'b0;
    check({tag, "_lat"},   lat, 4);
    check({tag, "_busy"},  busy_cnt, 4);
    check({tag, "_sum"},   bus8.sum, es);
    check({tag, "_carry"}, bus8.carry, ec);
    check({tag, "_ovf"},   bus8.ovf, ev);
  endtask

  task automatic w4_obs(input string tag, input int nchk, input logic dn, input logic [3:0] s,
                        input logic cy, input logic ov, input int waited,
                        input longint es, input bit ec, input bit ev, inout bit got);
    if (!got && dn === 1'b1) begin
      got = 1'b1;
      check({tag, "_lat"},   waited, nchk);
      check({tag, "_sum"},   s, es);
      check({tag, "_carry"}, cy, ec);
      check({tag, "_ovf"},   ov, ev);
    end
  endtask

  initial begin
    longint es;
    bit     ec, ev, seen, got1, got2, got4;
    int     n;

    rst        = 1'b1;
    bus8.start = 1'b0;
    bus8.a     = '0;
    bus8.b     = '0;
    bus8.cin   = 1'b0;
    s4_start   = 1'b0;
    s4_a       = '0;
    s4_b       = '0;
    s4_cin     = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    check("rst_busy",  bus8.busy, 0);
    check("rst_done",  bus8.done, 0);
    check("rst_sum",   bus8.sum, 0);
    check("rst_carry", bus8.carry, 0);
    check("rst_ovf",   bus8.ovf, 0);

    add8(8'h00, 8'h00, 1'b0, 1'b0, "t1");
    add8(8'hFF, 8'h01, 1'b0, 1'b0, "t2a");
    check("t2a_const_sum", bus8.sum, 8'h00);
    check("t2a_const_carry", bus8.carry, 1);
    tick();
    check("t2_done_pulse", bus8.done, 0);
    check("t2_hold_carry", bus8.carry, 1);
    add8(8'hFF, 8'hFF, 1'b1, 1'b0, "t2b");
    check("t2b_const_sum", bus8.sum, 8'hFF);
    add8(8'h7F, 8'h01, 1'b0, 1'b0, "t3");
    check("t3_const_sum", bus8.sum, 8'h80);
    add8(8'h10, 8'h20, 1'b0, 1'b1, "t4");
    check("t4_const_sum", bus8.sum, 8'h30);

    // Reset in the second RUN cycle abandons the add.
    bus8.start = 1'b1;
    bus8.a     = 8'h55;
    bus8.b     = 8'h22;
    tick();
    bus8.start = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    check("t5_busy",  bus8.busy, 0);
    check("t5_done",  bus8.done, 0);
    check("t5_sum",   bus8.sum, 0);
    check("t5_carry", bus8.carry, 0);
    check("t5_ovf",   bus8.ovf, 0);
    #2;
    rst  = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus8.done === 1'b1) seen = 1'b1;
    end
    check("t5_nodone", seen, 0);
    add8(8'h03, 8'h04, 1'b0, 1'b0, "t5b");

    // Start held high through DONE: second add accepted back-to-back.
    bus8.start = 1'b1;
    bus8.a     = 8'h12;
    bus8.b     = 8'h34;
    bus8.cin   = 1'b0;
    tick();
    bus8.a   = 8'h56;
    bus8.b   = 8'h78;
    bus8.cin = 1'b1;
    n = 0;
    while (bus8.done !== 1'b1 && n < 20) begin tick(); n++; end
    check("t6_lat1", n, 4);
    check("t6_sum1", bus8.sum, 8'h46);
    tick();
    bus8.start = 1'b0;
    n = 1;
    while (bus8.done !== 1'b1 && n < 20) begin tick(); n++; end
    ref_add(8, 64'h56, 64'h78, 1, es, ec, ev);
    check("t6_gap",   n, 5);
    check("t6_sum2",  bus8.sum, es);
    check("t6_carry2", bus8.carry, ec);
    check("t6_ovf2",  bus8.ovf, ev);
    tick();

    for (int i = 0; i < 150; i++)
      add8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0, "rnd");

    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        for (int c = 0; c < 2; c++) begin
          ref_add(4, longint'(x), longint'(y), longint'(c), es, ec, ev);
          s4_a     = 4'(x);
          s4_b     = 4'(y);
          s4_cin   = 1'(c);
          s4_start = 1'b1;
          tick();
          s4_start = 1'b0;
          got1 = 1'b0;
          got2 = 1'b0;
          got4 = 1'b0;
          n    = 0;
          while (!(got1 && got2 && got4) && n < 12) begin
            w4_obs("w4c1", 4, if4_1.done, if4_1.sum, if4_1.carry, if4_1.ovf, n, es, ec, ev, got1);
            w4_obs("w4c2", 2, if4_2.done, if4_2.sum, if4_2.carry, if4_2.ovf, n, es, ec, ev, got2);
            w4_obs("w4c4", 1, if4_4.done, if4_4.sum, if4_4.carry, if4_4.ovf, n, es, ec, ev, got4);
            if (!(got1 && got2 && got4)) begin
              tick();
              n++;
            end
          end
          check("w4_alldone", {got1, got2, got4}, 3'b111);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
